// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing (hs/vs/blank/coordinates) plus a FIFO-fed RGB pixel path.
// Define VTG_PATTERN_EN to show colour bars in the active area while waiting for the FIFO to fill.
module video_timing_gen #(
    parameter int HDISP  = 800,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VDISP  = 480,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic                                          pixel_clk,
    input  logic                                          pixel_rst,
    input  logic [23:0]                                   fifo_rdata,
    input  logic                                          fifo_empty,
    input  logic                                          fifo_full,
    output logic                                          fifo_read,
    output logic                                          video_hs,
    output logic                                          video_vs,
    output logic                                          video_blank,
    output logic [23:0]                                   video_rgb,
    output logic [$clog2(HDISP+HFP+HPULSE+HBP)-1:0]       pixel_x,
    output logic [$clog2(VDISP+VFP+VPULSE+VBP)-1:0]       pixel_y,
    output logic                                          frame_start,
    output logic                                          underflow
);

    localparam int HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    localparam logic [HW-1:0] H_ZERO     = HW'(0);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
    localparam logic [HW-1:0] H_LAST     = HW'(HTOT - 1);
    localparam logic [VW-1:0] V_ZERO     = VW'(0);
    localparam logic [VW-1:0] V_ONE      = VW'(1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOT - 1);

    typedef enum logic [0:0] {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t        state_r;
    logic [HW-1:0] h_r;
    logic [VW-1:0] v_r;
    logic          hs_r;
    logic          vs_r;
    logic          blank_r;
    logic [23:0]   rgb_r;
    logic          frame_start_r;
    logic          underflow_r;

    logic          h_last_s;
    logic          v_last_s;
    logic          hact_s;
    logic          vact_s;
    logic          hsync_s;
    logic          vsync_s;
    logic          active_s;
    logic          pop_s;
    logic          starve_s;
    logic [23:0]   idle_rgb_s;
    logic [23:0]   rgb_next_s;

    // Region decode of the current counter position and FIFO pop/starve conditions
    always_comb begin
        h_last_s = (h_r == H_LAST);
        v_last_s = (v_r == V_LAST);
        hact_s   = (h_r < H_ACT_END);
        vact_s   = (v_r < V_ACT_END);
        hsync_s  = (h_r >= H_SYNC_BEG) && (h_r < H_SYNC_END);
        vsync_s  = (v_r >= V_SYNC_BEG) && (v_r < V_SYNC_END);
        active_s = hact_s & vact_s;
        pop_s    = (state_r == RUN) & active_s & ~fifo_empty;
        starve_s = (state_r == RUN) & active_s & fifo_empty;
    end

`ifdef VTG_PATTERN_EN
    logic [2:0] bar_s;

    // Eight 100-pixel colour bars shown while the FIFO is still priming
    always_comb begin
        bar_s = 3'(32'(h_r) / 32'd100);
        case (bar_s)
            3'd0:    idle_rgb_s = 24'hFFFFFF;
            3'd1:    idle_rgb_s = 24'hFFFF00;
            3'd2:    idle_rgb_s = 24'h00FFFF;
            3'd3:    idle_rgb_s = 24'h00FF00;
            3'd4:    idle_rgb_s = 24'hFF00FF;
            3'd5:    idle_rgb_s = 24'hFF0000;
            3'd6:    idle_rgb_s = 24'h0000FF;
            default: idle_rgb_s = 24'h000000;
        endcase
    end
`else
    assign idle_rgb_s = 24'h000000;
`endif

    // Next pixel colour: FIFO head on a pop, idle fill in the active area before priming, else black
    always_comb begin
        if (pop_s) begin
            rgb_next_s = fifo_rdata;
        end else if ((state_r == WAIT_FILL) && active_s) begin
            rgb_next_s = idle_rgb_s;
        end else begin
            rgb_next_s = 24'h000000;
        end
    end

    // Raster counters, priming state machine and registered video outputs
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_r       <= WAIT_FILL;
            h_r           <= H_ZERO;
            v_r           <= V_ZERO;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_r       <= 1'b1;
            rgb_r         <= 24'h000000;
            frame_start_r <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            h_r <= h_last_s ? H_ZERO : (h_r + H_ONE);
            if (h_last_s) begin
                v_r <= v_last_s ? V_ZERO : (v_r + V_ONE);
            end

            case (state_r)
                WAIT_FILL: begin
                    // Leave only at the frame wrap so the first RUN pixel is (0,0)
                    if (h_last_s && v_last_s && fifo_full) begin
                        state_r <= RUN;
                    end
                end
                RUN:     state_r <= RUN;
                default: state_r <= WAIT_FILL;
            endcase

            hs_r          <= ~hsync_s;
            vs_r          <= ~vsync_s;
            blank_r       <= ~active_s;
            rgb_r         <= rgb_next_s;
            frame_start_r <= (h_r == H_ZERO) && (v_r == V_ZERO);
            underflow_r   <= underflow_r | starve_s;
        end
    end

    assign fifo_read   = pop_s;
    assign video_hs    = hs_r;
    assign video_vs    = vs_r;
    assign video_blank = blank_r;
    assign video_rgb   = rgb_r;
    assign pixel_x     = h_r;
    assign pixel_y     = v_r;
    assign frame_start = frame_start_r;
    assign underflow   = underflow_r;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-domain stage sitting directly downstream of the pixel-reset synchroniser; runs on the 32 MHz pixel clock.
- Generates the 800x480 LCD/HDMI raster timing: horizontal sync, vertical sync, blanking and pixel coordinates.
- Pops 24-bit RGB pixels from a show-ahead pixel FIFO filled upstream from SDRAM, and drives the video output bundle that goes to the hardware support.
- Holds reads off until the FIFO is primed at a frame boundary, and flags any underflow.

Parameters:
HDISP, 800, active pixels per line
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, hsync width (pixels)
HBP, 40, horizontal back porch (pixels)
VDISP, 480, active lines per frame
VFP, 13, vertical front porch (lines)
VPULSE, 3, vsync width (lines)
VBP, 29, vertical back porch (lines)

Ports:
pixel_clk  input  1  pixel clock, 32 MHz
pixel_rst  input  1  synchronous, active-high reset
fifo_rdata  input  24  show-ahead FIFO head, {R,G,B}
fifo_empty  input  1  FIFO has no data
fifo_full  input  1  FIFO full; priming condition
fifo_read  output  1  pop request; combinational
video_hs  output  1  horizontal sync, active low
video_vs  output  1  vertical sync, active low
video_blank  output  1  high outside the active area
video_rgb  output  24  pixel colour
pixel_x  output  $clog2(HDISP+HFP+HPULSE+HBP)  current h counter
pixel_y  output  $clog2(VDISP+VFP+VPULSE+VBP)  current v counter
frame_start  output  1  one-cycle pulse at h=0, v=0
underflow  output  1  sticky underflow flag

Behaviour:
- Clock and reset: one clock, pixel_clk; reset pixel_rst is synchronous and active-high.
- Totals: HTOT = HDISP+HFP+HPULSE+HBP = 928; VTOT = VDISP+VFP+VPULSE+VBP = 525.
- h counter: counts 0..HTOT-1 every cycle, then wraps to 0.
- v counter: increments when h wraps; wraps to 0 after VTOT-1 (at h=HTOT-1, v=VTOT-1 both counters become 0).
- Both counters are exported unregistered as pixel_x and pixel_y.
- Region decode, h axis:
  - active: h < HDISP
  - hsync: HDISP+HFP <= h < HDISP+HFP+HPULSE
- Region decode, v axis:
  - active: v < VDISP
  - vsync: VDISP+VFP <= v < VDISP+VFP+VPULSE
- Registered outputs (one-cycle latency relative to the counters):
  - video_hs = ~hsync
  - video_vs = ~vsync
  - video_blank = ~(hact & vact)
- Reset values:
  - h = 0, v = 0
  - video_hs = 1, video_vs = 1, video_blank = 1
  - video_rgb = 0, frame_start = 0, underflow = 0
  - state = WAIT_FILL
- State machine:
  - WAIT_FILL: no FIFO reads; fifo_read = 0; video_rgb = 0 (black). Go to RUN at the cycle where h=HTOT-1, v=VTOT-1 and fifo_full=1, so the first RUN cycle is pixel (0,0).
  - RUN: fifo_read = hact & vact & ~fifo_empty.
- Pixel data path in RUN:
  - Active cycle with FIFO data: fifo_rdata is registered into video_rgb, aligned with video_blank.
  - Active cycle with fifo_empty=1: this is an underflow. Set underflow=1 (sticky until reset), output video_rgb = 24'h000000, no pop. The state stays RUN; no resync.
  - Blank cycles: video_rgb = 0 and fifo_read = 0.
- frame_start: registered and high for exactly one cycle, aligned with the first active pixel at (0,0); it pulses in both states.
- fifo_full is ignored while in RUN.
- Reset mid-frame: counters, outputs and state return to their reset values on the next edge; timing restarts at (0,0) in WAIT_FILL.

Optional Feature:
- Macro: VTG_PATTERN_EN.
- When defined: in WAIT_FILL the active area shows 8 vertical colour bars of 100 pixels each, selected by pixel_x[9:0]/100, in order white, yellow, cyan, green, magenta, red, blue, black (each component 8'hFF or 8'h00). The pattern uses the same one-cycle latency as FIFO data. RUN behaviour is unchanged.
- When undefined: WAIT_FILL outputs black; the bar logic is not synthesised.

Test Plan:
- Reset, then 2 frames with fifo_empty=1 and fifo_full=0:
  - video_hs low for exactly 48 cycles per 928-cycle line; video_vs low for exactly 3x928 cycles per 525-line frame.
  - fifo_read never asserted; underflow stays 0; frame_start pulses every 487200 cycles.
- FIFO model held full (fifo_full=1), incrementing data:
  - entry to RUN at the first frame wrap.
  - exactly 384000 pops per frame; video_rgb reproduces the data sequence with blank=0 only in the active area.
- In RUN, force fifo_empty=1 for pixel (10,5):
  - underflow rises and stays 1; video_rgb = 0 on that pixel; the next pixel resumes with the unpopped data.
- Assert pixel_rst at (400,200):
  - next cycle: h=0, v=0, hs=vs=blank=1, rgb=0, state WAIT_FILL; no read until the next frame wrap with fifo_full=1.
- fifo_full=1 asserted only at h=HTOT-2 of the last line, dropped before h=HTOT-1:
  - stays in WAIT_FILL for that frame; enters RUN one frame later when fifo_full=1 at the wrap.
- With VTG_PATTERN_EN, in WAIT_FILL:
  - pixel_x = 0 gives rgb 24'hFFFFFF; 150 gives 24'hFFFF00; 799 gives 24'h000000, all one cycle later.
